// File: rtl/video_timing_ctrl.sv
// Raster timing generator: h/v counters with a run/drain/idle controller, a
// one-cycle pixel request stage and a 3-stage aligned video output pipeline.
module video_timing_ctrl #(
   parameter int H_SYNC   = 40,
   parameter int H_BACK   = 220,
   parameter int H_DISP   = 1280,
   parameter int H_FRONT  = 110,
   parameter int V_SYNC   = 5,
   parameter int V_BACK   = 20,
   parameter int V_DISP   = 720,
   parameter int V_FRONT  = 5,
   parameter int SYNC_POL = 1
) (
   input  logic        pclk,
   input  logic        reset_n,
   input  logic        en,
   input  logic [23:0] pixel_data,
   output logic        data_req,
   output logic [11:0] pixel_x,
   output logic [11:0] pixel_y,
   output logic [23:0] video_din,
   output logic        video_hsync,
   output logic        video_vsync,
   output logic        video_de,
   output logic        frame_start,
   output logic        busy
);

   localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

   localparam logic [11:0] H_LAST    = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_LAST    = 12'(V_TOTAL - 1);
   localparam logic [11:0] H_SYNC_E  = 12'(H_SYNC);
   localparam logic [11:0] V_SYNC_E  = 12'(V_SYNC);
   localparam logic [11:0] H_ACT_S   = 12'(H_SYNC + H_BACK);
   localparam logic [11:0] H_ACT_E   = 12'(H_SYNC + H_BACK + H_DISP);
   localparam logic [11:0] V_ACT_S   = 12'(V_SYNC + V_BACK);
   localparam logic [11:0] V_ACT_E   = 12'(V_SYNC + V_BACK + V_DISP);
   localparam logic        SYNC_ACT  = (SYNC_POL != 0);
   localparam logic        SYNC_IDLE = !SYNC_ACT;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [11:0] h_cnt;
   logic [11:0] v_cnt;
   logic        frame_last;
   logic        running;
   logic        act0;
   logic        hs0;
   logic        vs0;
   logic        fs0;
   logic        hs1;
   logic        vs1;
   logic        fs1;
   logic        de2;
   logic        hs2;
   logic        vs2;
   logic        fs2;

   assign frame_last = (h_cnt == H_LAST) && (v_cnt == V_LAST);
   assign running    = (state != IDLE);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge pclk) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------- FSM: next state ----------------
   // DRAIN only leaves to IDLE on the frame's last count, so frames never truncate.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (en) state_nxt = RUN;
         RUN:     if (!en) state_nxt = DRAIN;
         DRAIN: begin
            if (en) begin
               state_nxt = RUN;
            end else if (frame_last) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy = running;
   end

   // ---------------- raster counters ----------------
   always_ff @(posedge pclk) begin
      if (!reset_n || !running) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
      end else begin
         h_cnt <= h_cnt + 12'd1;
      end
   end

   // Stage 0: decode the counter position; idle feeds inactive values.
   assign act0 = running
                 && (h_cnt >= H_ACT_S) && (h_cnt < H_ACT_E)
                 && (v_cnt >= V_ACT_S) && (v_cnt < V_ACT_E);
   assign hs0  = running && (h_cnt < H_SYNC_E);
   assign vs0  = running && (v_cnt < V_SYNC_E);
   assign fs0  = running && (h_cnt == 12'd0) && (v_cnt == 12'd0);

   // Handshake: data_req is a one-cycle request for (pixel_x, pixel_y); the
   // source must present that pixel on pixel_data in the following cycle, and
   // it is captured at the end of that cycle into video_din with video_de.
   always_ff @(posedge pclk) begin
      if (!reset_n) begin
         data_req <= 1'b0;
         pixel_x  <= '0;
         pixel_y  <= '0;
         hs1      <= 1'b0;
         vs1      <= 1'b0;
         fs1      <= 1'b0;
      end else begin
         data_req <= act0;
         pixel_x  <= act0 ? (h_cnt - H_ACT_S) : 12'd0;
         pixel_y  <= act0 ? (v_cnt - V_ACT_S) : 12'd0;
         hs1      <= hs0;
         vs1      <= vs0;
         fs1      <= fs0;
      end
   end

   // Stage 2: the source's pixel is on pixel_data during this stage.
   always_ff @(posedge pclk) begin
      if (!reset_n) begin
         de2 <= 1'b0;
         hs2 <= 1'b0;
         vs2 <= 1'b0;
         fs2 <= 1'b0;
      end else begin
         de2 <= data_req;
         hs2 <= hs1;
         vs2 <= vs1;
         fs2 <= fs1;
      end
   end

   // Stage 3: aligned video outputs, polarity applied at the register.
   always_ff @(posedge pclk) begin
      if (!reset_n) begin
         video_de    <= 1'b0;
         video_din   <= '0;
         video_hsync <= SYNC_IDLE;
         video_vsync <= SYNC_IDLE;
         frame_start <= 1'b0;
      end else begin
         video_de    <= de2;
         video_din   <= de2 ? pixel_data : 24'd0;
         video_hsync <= hs2 ? SYNC_ACT : SYNC_IDLE;
         video_vsync <= vs2 ? SYNC_ACT : SYNC_IDLE;
         frame_start <= fs2;
      end
   end

endmodule
